// File: rtl/ifetch_unit.sv
// Instruction fetch back end: issues in-order reads for accepted PCs, buffers {pc, inst} for decode,
// discards in-flight responses after a redirect, and halts on a misaligned fetch address.
module ifetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_valid,
  input  logic [63:0] pc,
  output logic        pc_ready,
  input  logic        flush,
  output logic        req_valid,
  output logic [63:0] req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_misalign,
  output logic [63:0] fetch_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int UW = CW + 1;

  typedef enum logic [1:0] {RUN, HALT, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] outst;
  logic [CW-1:0] cnt;
  logic [CW-1:0] drop;
  logic [CW-1:0] outst_after_resp;

  logic [63:0]   aq_mem [DEPTH];
  logic [AW-1:0] aq_wr;
  logic [AW-1:0] aq_rd;

  logic [63:0]   ib_pc   [DEPTH];
  logic [31:0]   ib_inst [DEPTH];
  logic [AW-1:0] ib_wr;
  logic [AW-1:0] ib_rd;

  logic [UW-1:0] used;
  logic          space;
  logic          aligned;
  logic          fire;
  logic          take;
  logic          pop;
  logic          misalign_hit;

  // Outstanding plus buffered never exceeds DEPTH, so every response has a slot.
  assign used    = {1'b0, outst} + {1'b0, cnt};
  assign space   = used < UW'(DEPTH);
  assign aligned = (pc[1:0] == 2'b00);

  assign req_valid    = (state == RUN) && pc_valid && space && !flush && aligned;
  assign req_addr     = pc;
  assign fire         = req_valid && req_ready;
  assign pc_ready     = fire;
  assign misalign_hit = (state == RUN) && pc_valid && !aligned && !flush;

  assign take       = resp_valid && (state != DRAIN) && !flush;
  assign inst_valid = (cnt != '0) && !flush;
  assign pop        = inst_valid && inst_ready;
  assign inst       = ib_inst[ib_rd];
  assign inst_pc    = ib_pc[ib_rd];

  assign outst_after_resp = outst - CW'(resp_valid);

  always_ff @(posedge clk) begin
    if (fire) aq_mem[aq_wr] <= pc;
    if (take) begin
      ib_pc[ib_wr]   <= aq_mem[aq_rd];
      ib_inst[ib_wr] <= resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      outst          <= '0;
      cnt            <= '0;
      drop           <= '0;
      aq_wr          <= '0;
      aq_rd          <= '0;
      ib_wr          <= '0;
      ib_rd          <= '0;
      fetch_misalign <= 1'b0;
      fetch_pc       <= RESET_PC;
    end else begin
      outst <= outst + CW'(fire) - CW'(resp_valid);
      if (fire) begin
        aq_wr    <= aq_wr + 1'b1;
        fetch_pc <= pc;
      end
      if (flush) begin
        // Responses still owed by memory belong to the discarded path.
        aq_wr          <= '0;
        aq_rd          <= '0;
        ib_wr          <= '0;
        ib_rd          <= '0;
        cnt            <= '0;
        drop           <= outst_after_resp;
        fetch_misalign <= 1'b0;
        state          <= (outst_after_resp != '0) ? DRAIN : RUN;
      end else begin
        if (take) begin
          aq_rd <= aq_rd + 1'b1;
          ib_wr <= ib_wr + 1'b1;
        end
        if (pop) ib_rd <= ib_rd + 1'b1;
        cnt <= cnt + CW'(take) - CW'(pop);
        case (state)
          RUN: begin
            if (misalign_hit) begin
              fetch_misalign <= 1'b1;
              state          <= HALT;
            end
          end
          HALT: state <= HALT;
          DRAIN: begin
            if (resp_valid) begin
              drop <= drop - 1'b1;
              if (drop == CW'(1)) state <= RUN;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: streaming, backpressure, flush/drain, misalign halt and reset.
module tb_ifetch_unit;
  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic [63:0] pc;
  logic        pc_ready;
  logic        flush;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        fetch_misalign;
  logic [63:0] fetch_pc;

  int checks = 0;
  int failures = 0;
  bit auto_mem = 1'b0;
  bit gen_on = 1'b0;
  int mdl_outst = 0;
  int nfire = 0;
  logic [63:0] got_pc[$];
  logic [31:0] got_inst[$];

  always #5 clk = ~clk;

  ifetch_unit #(.DEPTH(4), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .fetch_misalign(fetch_misalign), .fetch_pc(fetch_pc)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then update PC generator and 1-cycle memory.
  task automatic tick();
    logic fired;
    logic [63:0] a;
    #1;
    fired = req_valid && req_ready && !rst;
    a = req_addr;
    if (inst_valid && inst_ready) begin
      got_pc.push_back(inst_pc);
      got_inst.push_back(inst);
    end
    if (resp_valid && !rst) check("resp_outst", 64'(mdl_outst != 0), 64'd1);
    @(posedge clk);
    #1;
    if (rst) mdl_outst = 0;
    else mdl_outst = mdl_outst + int'(fired) - int'(resp_valid);
    if (fired) nfire++;
    if (gen_on && fired) pc = pc + 64'd4;
    if (auto_mem) begin
      resp_valid = fired;
      resp_data  = fired ? mem_word(a) : 32'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; pc_valid = 1'b0; pc = RPC; req_ready = 1'b1;
    resp_valid = 1'b0; resp_data = 32'h0; inst_ready = 1'b0;
    auto_mem = 1'b0; gen_on = 1'b0;
    tick();
    rst = 1'b0;
    got_pc.delete();
    got_inst.delete();
    nfire = 0;
  endtask

  initial begin
    int bad;

    // Reset values and streaming
    do_reset();
    #1;
    check("rst_pc_ready", 64'(pc_ready), 64'd0);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_misalign", 64'(fetch_misalign), 64'd0);
    check("rst_fetch_pc", fetch_pc, RPC);
    pc_valid = 1'b1; gen_on = 1'b1; auto_mem = 1'b1; inst_ready = 1'b1;
    repeat (10) tick();
    check("t1_count", 64'(got_pc.size()), 64'd8);
    check("t1_pc0", got_pc[0], RPC);
    check("t1_pc1", got_pc[1], RPC + 64'd4);
    check("t1_pc2", got_pc[2], RPC + 64'd8);
    check("t1_inst0", 64'(got_inst[0]), 64'(mem_word(RPC)));

    // Decode stalled: at most DEPTH requests, then resume without loss
    do_reset();
    pc_valid = 1'b1; gen_on = 1'b1; auto_mem = 1'b1; inst_ready = 1'b0;
    repeat (8) tick();
    check("t2_fires", 64'(nfire), 64'd4);
    #1;
    check("t2_pc_ready_stall", 64'(pc_ready), 64'd0);
    check("t2_inst_valid", 64'(inst_valid), 64'd1);
    inst_ready = 1'b1;
    repeat (12) tick();
    check("t2_count_ge8", 64'(got_pc.size() >= 8), 64'd1);
    check("t2_first", got_pc[0], RPC);
    bad = 0;
    for (int i = 0; i < got_pc.size(); i++) begin
      if (got_pc[i] !== RPC + 64'(4 * i)) bad++;
      if (got_inst[i] !== mem_word(RPC + 64'(4 * i))) bad++;
    end
    check("t2_order", 64'(bad), 64'd0);

    // Flush with two requests in flight
    do_reset();
    pc_valid = 1'b1; gen_on = 1'b1; inst_ready = 1'b1;
    tick();
    tick();
    gen_on = 1'b0; pc = RPC + 64'h100; flush = 1'b1;
    #1;
    check("t3_flush_no_req", 64'(req_valid), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    check("t3_drain_no_req", 64'(req_valid), 64'd0);
    resp_valid = 1'b1; resp_data = 32'h0000_AAAA;
    tick();
    #1;
    check("t3_drop_a", 64'(inst_valid), 64'd0);
    resp_data = 32'h0000_BBBB;
    tick();
    resp_valid = 1'b0;
    #1;
    check("t3_drop_b", 64'(inst_valid), 64'd0);
    check("t3_resume_req", 64'(req_valid), 64'd1);
    check("t3_resume_addr", req_addr, RPC + 64'h100);
    auto_mem = 1'b1; gen_on = 1'b1;
    repeat (6) tick();
    check("t3_first_pc", got_pc[0], RPC + 64'h100);
    check("t3_first_inst", 64'(got_inst[0]), 64'(mem_word(RPC + 64'h100)));

    // Flush coinciding with a response and a decode pop
    do_reset();
    pc_valid = 1'b1; gen_on = 1'b1; inst_ready = 1'b0;
    repeat (3) tick();
    gen_on = 1'b0; pc_valid = 1'b0;
    resp_valid = 1'b1; resp_data = mem_word(RPC);
    tick();
    #1;
    check("t4_buffered", 64'(inst_valid), 64'd1);
    inst_ready = 1'b1; resp_data = mem_word(RPC + 64'd4); flush = 1'b1;
    #1;
    check("t4_pop_masked", 64'(inst_valid), 64'd0);
    tick();
    flush = 1'b0; resp_valid = 1'b0; pc_valid = 1'b1; pc = RPC + 64'h200;
    #1;
    check("t4_empty", 64'(inst_valid), 64'd0);
    check("t4_drain_one", 64'(req_valid), 64'd0);
    resp_valid = 1'b1; resp_data = mem_word(RPC + 64'd8);
    tick();
    resp_valid = 1'b0;
    #1;
    check("t4_dropped", 64'(inst_valid), 64'd0);
    check("t4_back_run", 64'(req_valid), 64'd1);
    check("t4_no_dup", 64'(got_pc.size()), 64'd0);
    auto_mem = 1'b1; gen_on = 1'b1;
    repeat (6) tick();
    check("t4_count", 64'(got_pc.size()), 64'd4);
    check("t4_first_pc", got_pc[0], RPC + 64'h200);

    // Misaligned fetch halts until flush
    do_reset();
    inst_ready = 1'b1; auto_mem = 1'b1;
    pc_valid = 1'b1; pc = RPC + 64'd2;
    #1;
    check("t5_no_req", 64'(req_valid), 64'd0);
    check("t5_no_ready", 64'(pc_ready), 64'd0);
    tick();
    check("t5_misalign", 64'(fetch_misalign), 64'd1);
    check("t5_fetch_pc", fetch_pc, RPC);
    pc = RPC + 64'd8;
    #1;
    check("t5_halt_ready", 64'(pc_ready), 64'd0);
    tick();
    check("t5_sticky", 64'(fetch_misalign), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("t5_cleared", 64'(fetch_misalign), 64'd0);
    check("t5_resume_ready", 64'(pc_ready), 64'd1);
    gen_on = 1'b1;
    repeat (5) tick();
    check("t5_first_pc", got_pc[0], RPC + 64'd8);

    // Reset with a full buffer
    do_reset();
    pc_valid = 1'b1; gen_on = 1'b1; auto_mem = 1'b1; inst_ready = 1'b0;
    repeat (8) tick();
    #1;
    check("t6_full", 64'(inst_valid), 64'd1);
    check("t6_full_fetch_pc", fetch_pc, RPC + 64'd12);
    rst = 1'b1; pc_valid = 1'b0; gen_on = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("t6_inst_valid", 64'(inst_valid), 64'd0);
    check("t6_fetch_pc", fetch_pc, RPC);
    check("t6_pc_ready_idle", 64'(pc_ready), 64'd0);
    pc_valid = 1'b1; pc = RPC;
    #1;
    check("t6_pc_ready", 64'(pc_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
